// File: rtl/nmcu_mem_arbiter.sv
// nmcu_pkg: shared memory-port types for the NMCU.
//   mem_req_t  : valid, we, addr, wdata, len (burst length, 0 means 1)
//   mem_resp_t : valid, addr, rdata, hit
package nmcu_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;
  localparam int LEN_WIDTH  = 4;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [LEN_WIDTH-1:0]  len;
  } mem_req_t;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  hit;
  } mem_resp_t;
endpackage

// nmcu_mem_arbiter: round-robin arbiter of NUM_REQ requesters onto one
// memory port. Write bursts lock the grant to their owner; reads are
// tracked in a MAX_OUTST-deep FIFO of {owner, beats} so in-order read data
// can be steered back to the requester that asked for it.
//   clk, rst      : clock, asynchronous active-high reset
//   req_i         : per-requester request (.valid qualifies)
//   req_ready_o   : per-requester accept
//   resp_o        : per-requester read response (one-cycle .valid pulse)
//   mem_req_o     : request to the shared memory port
//   mem_ready_i   : memory accepts mem_req_o this cycle
//   mem_resp_i    : in-order read data from memory, one word per valid
//   err_o         : sticky flag, response arrived with nothing outstanding
module nmcu_mem_arbiter
  import nmcu_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_OUTST = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  mem_req_t           req_i [NUM_REQ],
  output logic [NUM_REQ-1:0] req_ready_o,
  output mem_resp_t          resp_o [NUM_REQ],
  output mem_req_t           mem_req_o,
  input  logic               mem_ready_i,
  input  mem_resp_t          mem_resp_i,
  output logic               err_o
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int PW  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  typedef enum logic {IDLE, WR_BURST} state_t;

  state_t               state_q, state_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [IDW-1:0]       owner_q, owner_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic                 err_q;

  logic [IDW-1:0]       fifo_id_q    [MAX_OUTST];
  logic [LEN_WIDTH-1:0] fifo_beats_q [MAX_OUTST];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [PW:0]          count_q;

  logic                 fifo_empty, fifo_full;
  logic [IDW-1:0]       head_id;
  logic [LEN_WIDTH-1:0] head_beats;
  logic                 resp_hit, pop, read_ok;

  logic                 win_found;
  logic [IDW-1:0]       win_id;
  int                   scan_j;

  logic [IDW-1:0]       sel_id;
  mem_req_t             sel_req;
  logic                 fwd;
  logic                 push;
  logic [LEN_WIDTH-1:0] sel_el;

  function automatic logic [LEN_WIDTH-1:0] eff_len(input logic [LEN_WIDTH-1:0] len);
    return (len == '0) ? LEN_WIDTH'(1) : len;
  endfunction

  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    return (int'(id) == NUM_REQ - 1) ? '0 : id + 1'b1;
  endfunction

  function automatic logic [PW-1:0] next_slot(input logic [PW-1:0] p);
    return (int'(p) == MAX_OUTST - 1) ? '0 : p + 1'b1;
  endfunction

  // Read-tracking FIFO status and response steering
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (PW+1)'(MAX_OUTST));
  assign head_id    = fifo_id_q[rd_ptr_q];
  assign head_beats = fifo_beats_q[rd_ptr_q];
  assign resp_hit   = !rst && mem_resp_i.valid && !fifo_empty;
  assign pop        = resp_hit && (head_beats == LEN_WIDTH'(1));
  // A pop in the same cycle frees the slot, so a read may enter a full FIFO.
  assign read_ok    = !fifo_full || pop;
  assign err_o      = err_q;

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      resp_o[k] = '0;
      if (resp_hit && (head_id == IDW'(k))) begin
        resp_o[k].valid = 1'b1;
        resp_o[k].addr  = mem_resp_i.addr;
        resp_o[k].rdata = mem_resp_i.rdata;
        resp_o[k].hit   = mem_resp_i.hit;
      end
    end
  end

  // Round-robin scan from ptr; reads that cannot be tracked are skipped.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_j    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_j = int'(ptr_q) + k;
      if (scan_j >= NUM_REQ) scan_j = scan_j - NUM_REQ;
      if (!win_found && req_i[scan_j].valid && (req_i[scan_j].we || read_ok)) begin
        win_found = 1'b1;
        win_id    = IDW'(scan_j);
      end
    end
  end

  // Grant, forwarding and next-state
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    mem_req_o   = '0;
    req_ready_o = '0;
    push        = 1'b0;
    sel_id      = (state_q == WR_BURST) ? owner_q : win_id;
    sel_req     = req_i[sel_id];
    sel_el      = eff_len(sel_req.len);
    fwd         = (state_q == WR_BURST) ? (sel_req.valid && sel_req.we) : win_found;

    if (!rst && fwd) begin
      mem_req_o           = sel_req;
      mem_req_o.valid     = 1'b1;
      req_ready_o[sel_id] = mem_ready_i;
      if (mem_ready_i) begin
        if (state_q == IDLE) begin
          if (!sel_req.we) begin
            push  = 1'b1;
            ptr_d = next_id(sel_id);
          end else if (sel_el == LEN_WIDTH'(1)) begin
            ptr_d = next_id(sel_id);
          end else begin
            cnt_d   = sel_el - LEN_WIDTH'(1);
            owner_d = sel_id;
            state_d = WR_BURST;
          end
        end else begin
          cnt_d = cnt_q - LEN_WIDTH'(1);
          if (cnt_q == LEN_WIDTH'(1)) begin
            ptr_d   = next_id(owner_q);
            state_d = IDLE;
          end
        end
      end
    end
  end

  // Control state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      if (mem_resp_i.valid && fifo_empty) err_q <= 1'b1;
      if (push) wr_ptr_q <= next_slot(wr_ptr_q);
      if (pop)  rd_ptr_q <= next_slot(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO payload; only read while count_q says the slot is live
  always_ff @(posedge clk) begin
    if (resp_hit && !pop) fifo_beats_q[rd_ptr_q] <= head_beats - LEN_WIDTH'(1);
    if (push) begin
      fifo_id_q[wr_ptr_q]    <= sel_id;
      fifo_beats_q[wr_ptr_q] <= sel_el;
    end
  end

endmodule

// File: doc/nmcu_mem_arbiter.md
NMCU_MEM_ARBITER -- requirements
Module: nmcu_mem_arbiter

Interface
REQ-001 SHALL import nmcu_pkg; mem_req_t and mem_resp_t are the package types; DATA_WIDTH, ADDR_WIDTH and LEN_WIDTH come from nmcu_pkg.
REQ-002 Parameter NUM_REQ, default 4: number of requesters, range 2..8.
REQ-003 Parameter MAX_OUTST, default 4: depth of the outstanding-read tracking FIFO, power of 2.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req_i  input  mem_req_t[NUM_REQ]  per-requester request; .valid qualifies.
REQ-007 req_ready_o  output  [NUM_REQ]  per-requester accept; beat transfers when req_i[k].valid && req_ready_o[k].
REQ-008 resp_o  output  mem_resp_t[NUM_REQ]  per-requester read response; .valid is a one-cycle pulse.
REQ-009 mem_req_o  output  mem_req_t  request to the shared memory port.
REQ-010 mem_ready_i  input  1  memory accepts mem_req_o this cycle.
REQ-011 mem_resp_i  input  mem_resp_t  memory read data; returned in request order, one word per valid.

Function
REQ-012 Effective burst length SHALL be EL = (len == 0) ? 1 : len.
REQ-013 FSM states SHALL be IDLE and WR_BURST.
- IDLE: arbitrate.
- WR_BURST: grant locked to the write owner.
REQ-014 IDLE arbitration SHALL be round-robin.
- Winner: first requester with valid set, scanning from ptr, ptr+1, ... modulo NUM_REQ.
- Arbitration is combinational in the same cycle.
REQ-015 Eligibility SHALL be checked for the candidate in the scan.
- A read is ineligible while the FIFO is full.
- An ineligible read is skipped, and scanning continues to the next requester.
REQ-016 mem_req_o SHALL equal the winner's req_i with .valid set, and req_ready_o[winner] = mem_ready_i; every other req_ready_o SHALL be 0.
REQ-017 Read accept (IDLE):
- Push {owner id, EL} into the FIFO.
- Set ptr to winner+1.
- Stay in IDLE.
REQ-018 Write accept (IDLE):
- If EL == 1: set ptr to winner+1 and stay in IDLE.
- Otherwise: load beat counter = EL-1, latch owner, go to WR_BURST.
REQ-019 WR_BURST behaviour:
- Only the owner is forwarded; all other requesters see ready 0.
- On each accepted beat, the counter decrements.
- When the accepted beat has counter == 1: set ptr to owner+1 and go to IDLE.
REQ-020 In WR_BURST, if the owner drops valid, mem_req_o.valid SHALL be 0 and the counter SHALL hold; a read from the owner is not expected and is not forwarded.
REQ-021 Each mem_resp_i.valid SHALL route to resp_o[head owner] in the same cycle (combinational), with .addr, .rdata and .hit copied; all other resp_o[*].valid SHALL be 0.
- The head beat count decrements.
- At 1, the FIFO pops.
REQ-022 When a push and a pop occur in the same cycle, both SHALL take effect; a push SHALL be allowed while the FIFO is full only if a pop occurs in the same cycle.
REQ-023 mem_resp_i.valid with the FIFO empty SHALL be dropped, and the sticky output err_o (output, 1) SHALL be set until reset.
REQ-024 Round-robin ptr SHALL advance only on transaction completion, never on a stalled cycle (mem_ready_i = 0), so the offered request is held stable.

Reset
REQ-025 On rst assertion, regardless of clock:
- state = IDLE, ptr = 0, FIFO empty, beat counter = 0, err_o = 0.
- All req_ready_o = 0, all resp_o[*].valid = 0, mem_req_o.valid = 0.
REQ-026 Reset mid-burst or with reads outstanding SHALL discard all tracking; responses arriving after reset SHALL be handled per REQ-023.
REQ-027 Outputs SHALL be driven only from state and current inputs; there are no X on outputs after reset.

Verification
REQ-028 Contention:
- Stimulus: all 4 requesters issue single-word reads, mem_ready_i = 1, rst released with ptr = 0.
- Required: grants in order 0,1,2,3, one per cycle.
- Required: responses with rdata 0xA0..0xA3 appear on resp_o[0..3] in that order.
REQ-029 Write burst lock:
- Stimulus: req 1 issues a write with len = 4; req 2 issues a read concurrently.
- Required: four consecutive beats from req 1 on mem_req_o with no interleave.
- Required: req 2 is granted on the 5th accepting cycle.
REQ-030 Backpressure:
- Stimulus: mem_ready_i = 0 for 3 cycles while req 0 is valid.
- Required: mem_req_o is stable; req_ready_o[0] = 0; ptr unchanged.
- Required: accept occurs on the cycle mem_ready_i rises.
REQ-031 FIFO full:
- Stimulus: MAX_OUTST = 4, with 4 reads outstanding.
- Required: a 5th read stalls while a write from another requester is granted.
- Required: after the next response pop, the read is accepted in that same cycle.
REQ-032 Burst read / len = 0:
- Stimulus: a read with len = 3, then a read with len = 0.
- Required: 3 responses route to the first owner, then 1 to the second.
- Stimulus: a stray mem_resp_i.valid with the FIFO empty.
- Required: err_o = 1.
REQ-033 Async reset:
- Stimulus: rst asserted mid WR_BURST between clock edges.
- Required: outputs reach reset values immediately.
- Required: after release, ptr = 0 arbitration resumes.
